// File: rtl/key_pkg.sv
// Shared types and sizing helper for the multi-channel key conditioner.
`default_nettype none

package key_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REL_DB = 2'd2
   } key_state_e;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, debounce/hold FSM, long-press and auto-repeat timers.
`default_nettype none

module key_channel
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CNT = 15,
   parameter int LONG_CNT     = 1000,
   parameter int REPEAT_CNT   = 200,
   parameter int REPEAT_EN    = 1
) (
   input  logic key_clk,
   input  logic key_rst_n,
   input  logic key_raw,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic key_repeat
);

   localparam int DW = cnt_width(DEBOUNCE_CNT);
   localparam int HW = cnt_width(LONG_CNT);
   localparam int RW = cnt_width(REPEAT_CNT);

   localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CNT);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CNT - 1);
   localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CNT);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CNT - 1);

   logic [1:0]    sync_q;
   key_state_e    state, state_nx;
   logic [DW-1:0] db_cnt, db_nx;
   logic [HW-1:0] hold_cnt, hold_nx;
   logic [RW-1:0] rep_cnt, rep_nx;
   logic          level_nx, press_nx, release_nx, long_nx, repeat_nx;
   logic          sample_low;

   assign sample_low = ~sync_q[1];

   always_ff @(posedge key_clk or negedge key_rst_n) begin
      if (!key_rst_n) begin
         sync_q      <= 2'b11;
         state       <= IDLE;
         db_cnt      <= '0;
         hold_cnt    <= '0;
         rep_cnt     <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         key_repeat  <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], key_raw};
         state       <= state_nx;
         db_cnt      <= db_nx;
         hold_cnt    <= hold_nx;
         rep_cnt     <= rep_nx;
         key_level   <= level_nx;
         key_press   <= press_nx;
         key_release <= release_nx;
         key_long    <= long_nx;
         key_repeat  <= repeat_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      db_nx      = db_cnt;
      hold_nx    = hold_cnt;
      rep_nx     = rep_cnt;
      level_nx   = key_level;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      long_nx    = 1'b0;
      repeat_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (!sample_low) begin
               db_nx = '0;
            end else if (db_cnt == DB_MAX) begin
               press_nx = 1'b1;
               level_nx = 1'b1;
               db_nx    = '0;
               hold_nx  = '0;
               rep_nx   = '0;
               state_nx = HELD;
            end else begin
               db_nx = db_cnt + DW'(1);
            end
         end
         HELD: begin
            // Timers still tick on the cycle that first sees the key high.
            if (hold_cnt != LONG_MAX) begin
               hold_nx = hold_cnt + HW'(1);
               long_nx = (hold_nx == LONG_MAX);
            end else if (REPEAT_EN != 0) begin
               if (rep_cnt == REP_LAST) begin
                  rep_nx    = '0;
                  repeat_nx = 1'b1;
               end else begin
                  rep_nx = rep_cnt + RW'(1);
               end
            end
            if (!sample_low) begin
               db_nx    = '0;
               state_nx = REL_DB;
            end
         end
         REL_DB: begin
            // The HELD exit already consumed one high sample, so stop one short.
            if (sample_low) begin
               db_nx    = '0;
               state_nx = HELD;
            end else if (db_cnt == DB_LAST) begin
               release_nx = 1'b1;
               level_nx   = 1'b0;
               db_nx      = '0;
               state_nx   = IDLE;
            end else begin
               db_nx = db_cnt + DW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/key_debounce_multi.sv
// N_KEYS independent key conditioners with press/release/long/repeat events.
`default_nettype none

module key_debounce_multi
   import key_pkg::*;
#(
   parameter int N_KEYS       = 4,
   parameter int DEBOUNCE_CNT = 15,
   parameter int LONG_CNT     = 1000,
   parameter int REPEAT_CNT   = 200,
   parameter int REPEAT_EN    = 1
) (
   input  logic              key_clk,
   input  logic              key_rst_n,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long,
   output logic [N_KEYS-1:0] key_repeat
);

   generate
      if (N_KEYS < 1) begin : g_bad_n_keys
         $fatal(1, "key_debounce_multi: N_KEYS must be >= 1");
      end
      if (DEBOUNCE_CNT < 1) begin : g_bad_debounce
         $fatal(1, "key_debounce_multi: DEBOUNCE_CNT must be >= 1");
      end
      if (LONG_CNT < 1) begin : g_bad_long
         $fatal(1, "key_debounce_multi: LONG_CNT must be >= 1");
      end
      if (REPEAT_CNT < 1) begin : g_bad_repeat
         $fatal(1, "key_debounce_multi: REPEAT_CNT must be >= 1");
      end
      if (REPEAT_EN != 0 && REPEAT_EN != 1) begin : g_bad_repeat_en
         $fatal(1, "key_debounce_multi: REPEAT_EN must be 0 or 1");
      end

      for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
         key_channel #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .LONG_CNT     (LONG_CNT),
            .REPEAT_CNT   (REPEAT_CNT),
            .REPEAT_EN    (REPEAT_EN)
         ) u_channel (
            .key_clk     (key_clk),
            .key_rst_n   (key_rst_n),
            .key_raw     (key_in[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i]),
            .key_repeat  (key_repeat[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi (DEBOUNCE_CNT=4, LONG_CNT=20, REPEAT_CNT=5).
`default_nettype none

module tb_key_debounce_multi;

   localparam int NK = 4;

   logic          clk;
   logic          rst_n;
   logic [NK-1:0] key_in;
   logic [NK-1:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
   logic [NK-1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;

   int n_checks = 0;
   int n_bad    = 0;

   key_debounce_multi #(
      .N_KEYS(NK), .DEBOUNCE_CNT(4), .LONG_CNT(20), .REPEAT_CNT(5), .REPEAT_EN(1)
   ) dut (
      .key_clk(clk), .key_rst_n(rst_n), .key_in(key_in),
      .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a),
      .key_long(lng_a), .key_repeat(rep_a)
   );

   key_debounce_multi #(
      .N_KEYS(NK), .DEBOUNCE_CNT(4), .LONG_CNT(20), .REPEAT_CNT(5), .REPEAT_EN(0)
   ) dut_norep (
      .key_clk(clk), .key_rst_n(rst_n), .key_in(key_in),
      .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b),
      .key_long(lng_b), .key_repeat(rep_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [NK-1:0] kin;
      int            cycles;
      logic [NK-1:0] lvl;
      logic [NK-1:0] prs;
      logic [NK-1:0] rel;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step(input logic [NK-1:0] kin);
      key_in = kin;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [NK-1:0] kin, input int cyc,
                      input logic [NK-1:0] lvl, input logic [NK-1:0] prs,
                      input logic [NK-1:0] rel);
      vecs.push_back('{kin, cyc, lvl, prs, rel});
   endtask

   // Drives channel ch low from t=0 (except a glitch window and from rel_in on)
   // and compares every cycle against hand-computed event times.
   task automatic run_seq(input string name, input int ch, input int n,
                          input int gs, input int gl, input int rel_in,
                          input int t_press, input int t_long, input int rep_end,
                          input int t_rel);
      logic [NK-1:0] kin;
      logic [NK-1:0] e_lvl, e_prs, e_rel, e_lng, e_rep;
      for (int t = 0; t < n; t++) begin
         kin     = '1;
         kin[ch] = ((t >= gs && t < gs + gl) || t >= rel_in) ? 1'b1 : 1'b0;
         step(kin);
         e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_rep = '0;
         e_lvl[ch] = (t >= t_press && t < t_rel);
         e_prs[ch] = (t == t_press);
         e_rel[ch] = (t == t_rel);
         e_lng[ch] = (t == t_long);
         e_rep[ch] = (t > t_long && t <= rep_end && ((t - t_long) % 5) == 0);
         check($sformatf("%s rep_en t=%0d {lvl,prs,rel,lng,rep}", name, t),
               32'({lvl_a, prs_a, rel_a, lng_a, rep_a}),
               32'({e_lvl, e_prs, e_rel, e_lng, e_rep}));
         check($sformatf("%s no_rep t=%0d {lvl,prs,rel,lng,rep}", name, t),
               32'({lvl_b, prs_b, rel_b, lng_b, rep_b}),
               32'({e_lvl, e_prs, e_rel, e_lng, 4'b0000}));
      end
   endtask

   initial begin
      logic [NK-1:0] stray;

      // Clean press/release of key 0: press at edge 6, release 6 edges after going high.
      add(4'hE, 6, 4'h0, 4'h0, 4'h0);
      add(4'hE, 1, 4'h1, 4'h1, 4'h0);
      add(4'hE, 3, 4'h1, 4'h0, 4'h0);
      add(4'hF, 6, 4'h1, 4'h0, 4'h0);
      add(4'hF, 1, 4'h0, 4'h0, 4'h1);
      add(4'hF, 3, 4'h0, 4'h0, 4'h0);
      // Keys 0 and 3 together.
      add(4'h6, 6, 4'h0, 4'h0, 4'h0);
      add(4'h6, 1, 4'h9, 4'h9, 4'h0);
      add(4'hF, 6, 4'h9, 4'h0, 4'h0);
      add(4'hF, 1, 4'h0, 4'h0, 4'h9);
      add(4'hF, 2, 4'h0, 4'h0, 4'h0);
      // Key 1 bouncing every 2 cycles, then a clean low.
      for (int i = 0; i < 5; i++) begin
         add(4'hD, 2, 4'h0, 4'h0, 4'h0);
         add(4'hF, 2, 4'h0, 4'h0, 4'h0);
      end
      add(4'hD, 6, 4'h0, 4'h0, 4'h0);
      add(4'hD, 1, 4'h2, 4'h2, 4'h0);
      add(4'hD, 3, 4'h2, 4'h0, 4'h0);
      add(4'hF, 6, 4'h2, 4'h0, 4'h0);
      add(4'hF, 1, 4'h0, 4'h0, 4'h2);
      add(4'hF, 3, 4'h0, 4'h0, 4'h0);

      key_in = '1;
      rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs", 32'({lvl_a, prs_a, rel_a, lng_a, rep_a}), 32'd0);
      check("reset outputs norep", 32'({lvl_b, prs_b, rel_b, lng_b, rep_b}), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         stray = '0;
         for (int c = 0; c < vecs[i].cycles; c++) begin
            step(vecs[i].kin);
            if (c < vecs[i].cycles - 1) stray |= prs_a | rel_a | lng_a | rep_a;
         end
         check($sformatf("vec%0d stray pulses", i), 32'(stray), 32'd0);
         check($sformatf("vec%0d level", i), 32'(lvl_a), 32'(vecs[i].lvl));
         check($sformatf("vec%0d press", i), 32'(prs_a), 32'(vecs[i].prs));
         check($sformatf("vec%0d release", i), 32'(rel_a), 32'(vecs[i].rel));
         check($sformatf("vec%0d long/repeat", i), 32'({lng_a, rep_a}), 32'd0);
      end

      // Long hold of key 2: press 6, long 26, repeats 31..66, leaves HELD at 68, release 72.
      run_seq("long", 2, 80, -1, 0, 66, 6, 26, 68, 72);

      // Two-cycle high glitch at t=15,16 freezes timers on edges 18 and 19: long moves to 28.
      run_seq("glitch", 2, 50, 15, 2, 40, 6, 28, 42, 46);

      // Reset while key 0 is held.
      for (int t = 0; t < 10; t++) step(4'hE);
      check("pre-reset level", 32'(lvl_a), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset outputs", 32'({lvl_a, prs_a, rel_a, lng_a, rep_a}), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("in-reset no release", 32'({lvl_a, prs_a, rel_a, lng_a, rep_a}), 32'd0);
      rst_n = 1'b1;
      run_seq("after_reset", 0, 10, -1, 0, 1000, 6, 1000, 0, 1000);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
